// File: rtl/vvp_acc_if.sv
// Handshake bundle between the vvp sequencer, the accumulator and the result consumer.
// The slave modport is the accumulator side; master is the upstream/downstream environment.
interface vvp_acc_if #(
    parameter int SW   = 8,
    parameter int ACCW = 32
);
    logic            s_valid;
    logic            s_ready;
    logic [SW-1:0]   s_data;
    logic            o_valid;
    logic            o_ready;
    logic [ACCW-1:0] o_data;

    modport master (
        output s_valid, s_data, o_ready,
        input  s_ready, o_valid, o_data
    );

    modport slave (
        input  s_valid, s_data, o_ready,
        output s_ready, o_valid, o_data
    );
endinterface

// File: rtl/vvp_acc.sv
// Shift-accumulates the signed per-plane partial sums of one vvp instance into a
// full-precision dot product, emitting one result per cfg_tiles groups of P beats.
module vvp_acc #(
    parameter int n       = 64,
    parameter int WBITS   = 2,
    parameter int DPLANES = 2,
    parameter int TW      = 8,
    parameter int ACCW    = 32,
    localparam int SW     = $clog2(n) + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic [TW-1:0] cfg_tiles_i,
    vvp_acc_if.slave      bus
);
    localparam int P   = WBITS * DPLANES;
    localparam int BW  = (P > 1) ? $clog2(P) : 1;
    localparam int SHW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_e;

    state_e          state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] oData_q, oData_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   tile_q, tile_d;
    logic [TW-1:0]   tiles_q, tiles_d;
    logic            rdyEn_q;

    logic [BW-1:0]   beatEff;
    logic [TW-1:0]   tileEff;
    logic [TW-1:0]   tilesEff;
    logic [ACCW-1:0] accBase;
    logic [SHW-1:0]  shAmt;
    logic [ACCW-1:0] sExt;
    logic [ACCW-1:0] contrib;
    logic [ACCW-1:0] sum;
    logic            accept;
    logic            lastBeat;
    logic            lastTile;
    logic            finalBeat;

    // Holds s_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdyEn_q <= 1'b0;
        end else begin
            rdyEn_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        state_d = finalBeat ? OUT : ACC;
                    end
                end
                OUT: begin
                    if (bus.o_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE, ACC: bus.s_ready = rdyEn_q;
            OUT:       bus.o_valid = 1'b1;
            default:   ;
        endcase
    end

    assign bus.o_data = oData_q;
    assign accept     = bus.s_valid && bus.s_ready;

    // In IDLE the incoming beat is treated as beat 0 of tile 0 on an empty accumulator,
    // so the first beat and every later beat share one datapath.
    always_comb begin
        beatEff   = (state_q == IDLE) ? '0 : beat_q;
        tileEff   = (state_q == IDLE) ? '0 : tile_q;
        tilesEff  = tiles_q;
        if (state_q == IDLE) begin
            tilesEff = (cfg_tiles_i == '0) ? TW'(1) : cfg_tiles_i;
        end
        accBase   = (state_q == IDLE) ? '0 : acc_q;
        shAmt     = SHW'((int'(beatEff) % WBITS) + 2 * (int'(beatEff) / WBITS));
        sExt      = {{(ACCW-SW){bus.s_data[SW-1]}}, bus.s_data};
        contrib   = sExt << shAmt;
        sum       = accBase + contrib;
        lastBeat  = (beatEff == BW'(P - 1));
        lastTile  = (tileEff == tilesEff - TW'(1));
        finalBeat = accept && lastBeat && lastTile;
    end

    always_comb begin
        acc_d   = acc_q;
        beat_d  = beat_q;
        tile_d  = tile_q;
        tiles_d = tiles_q;
        oData_d = oData_q;
        if (clr_i) begin
            acc_d  = '0;
            beat_d = '0;
            tile_d = '0;
        end else if (accept) begin
            acc_d   = sum;
            tiles_d = tilesEff;
            if (lastBeat) begin
                beat_d = '0;
                tile_d = lastTile ? '0 : tileEff + TW'(1);
            end else begin
                beat_d = beatEff + BW'(1);
                tile_d = tileEff;
            end
            if (finalBeat) begin
                oData_d = sum;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            oData_q <= '0;
            beat_q  <= '0;
            tile_q  <= '0;
            tiles_q <= '0;
        end else begin
            acc_q   <= acc_d;
            oData_q <= oData_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            tiles_q <= tiles_d;
        end
    end
endmodule

// File: tb/tb_vvp_acc.sv
// Directed bench for vvp_acc: hand-computed dot products with shifts 0,1,2,3 per 4-beat tile,
// plus backpressure, clr and asynchronous reset cases.
module tb_vvp_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] cfgTiles = 8'd1;
    int         checks = 0;
    int         errors = 0;

    vvp_acc_if #(.SW(8), .ACCW(32)) bus ();

    vvp_acc #(
        .n(64), .WBITS(2), .DPLANES(2), .TW(8), .ACCW(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .cfg_tiles_i(cfgTiles),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Presents one beat at a falling edge and holds it until accepted at a rising edge.
    task automatic applyStimulus(input logic signed [7:0] d);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 50) begin
            checkOutput("beatTimeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic applyGroup(input logic signed [7:0] d0, input logic signed [7:0] d1,
                              input logic signed [7:0] d2, input logic signed [7:0] d3);
        applyStimulus(d0);
        applyStimulus(d1);
        applyStimulus(d2);
        applyStimulus(d3);
    endtask

    // Called right after the final beat: the result must be visible one cycle later and pulse once.
    task automatic finishGroup(input string tag, input logic [31:0] exp);
        @(negedge clk);
        checkOutput({tag, "_oValid"}, 32'(bus.o_valid), 32'd1);
        checkOutput({tag, "_oData"}, bus.o_data, exp);
        checkOutput({tag, "_sReadyOut"}, 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, "_oValidDrop"}, 32'(bus.o_valid), 32'd0);
        checkOutput({tag, "_oDataHold"}, bus.o_data, exp);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.o_ready = 1'b1;

        #2;
        checkOutput("rst_sReady", 32'(bus.s_ready), 32'd0);
        checkOutput("rst_oValid", 32'(bus.o_valid), 32'd0);
        checkOutput("rst_oData", bus.o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_sReady", 32'(bus.s_ready), 32'd1);

        // 1 + 2 + 4 + 8
        applyGroup(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        finishGroup("t1_ones", 32'd15);

        applyGroup(-8'sd1, -8'sd1, -8'sd1, -8'sd1);
        finishGroup("t2_negOnes", -32'sd15);
        // 127 + (-128 << 3)
        applyGroup(8'sd127, 8'sd0, 8'sd0, -8'sd128);
        finishGroup("t2_extremes", -32'sd897);

        cfgTiles = 8'd2;
        applyStimulus(8'sd1);
        cfgTiles = 8'd1;
        applyStimulus(8'sd1);
        applyStimulus(8'sd1);
        applyStimulus(8'sd1);
        @(negedge clk);
        checkOutput("t3_midTile_oValid", 32'(bus.o_valid), 32'd0);
        applyGroup(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        finishGroup("t3_twoTiles", 32'd30);

        cfgTiles = 8'd0;
        applyGroup(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        finishGroup("t3_zeroTiles", 32'd15);
        cfgTiles = 8'd1;

        // 1 + 4 + 12 - 8 under backpressure, with a beat offered while the result is pending
        bus.o_ready = 1'b0;
        applyGroup(8'sd1, 8'sd2, 8'sd3, -8'sd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'sd5;
            checkOutput("t4_hold_oValid", 32'(bus.o_valid), 32'd1);
            checkOutput("t4_hold_oData", bus.o_data, 32'd9);
            checkOutput("t4_hold_sReady", 32'(bus.s_ready), 32'd0);
        end
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_release_oValid", 32'(bus.o_valid), 32'd0);
        applyGroup(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        finishGroup("t4_afterHold", 32'd15);

        bus.o_ready = 1'b0;
        applyGroup(8'sd3, 8'sd3, 8'sd3, 8'sd3);
        @(negedge clk);
        checkOutput("t5_outPending", 32'(bus.o_valid), 32'd1);
        clr = 1'b1;
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        checkOutput("t5_clrInOut_oValid", 32'(bus.o_valid), 32'd0);

        applyStimulus(8'sd5);
        applyStimulus(8'sd5);
        @(negedge clk);
        clr = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'sd7;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_clrInAcc_oValid", 32'(bus.o_valid), 32'd0);
        // 2 + 4 + 8 + 16
        applyGroup(8'sd2, 8'sd2, 8'sd2, 8'sd2);
        finishGroup("t5_afterClr", 32'd30);

        applyStimulus(8'sd1);
        applyStimulus(8'sd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_asyncRst_sReady", 32'(bus.s_ready), 32'd0);
        checkOutput("t6_asyncRst_oValid", 32'(bus.o_valid), 32'd0);
        checkOutput("t6_asyncRst_oData", bus.o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_rel_sReady", 32'(bus.s_ready), 32'd1);
        applyGroup(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        finishGroup("t6_afterRst", 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
